store_buffer: RTL
=================

Name: store_buffer

Overview:
- Write-side counterpart to the writeback-stage load lane extraction.
- Accepts committed stores from the memory stage and performs lane insertion: shifts data into its byte lanes and generates byte enables.
- Queues stores in a small FIFO and drains them to the data-memory write port with a req/ack handshake.
- Exposes a same-word hit signal so hazard logic can stall younger loads, and an empty flag for halt, sleep and rfe ordering.

Parameters:
- DEPTH, 4, number of queued store entries (power of two, ≥2).
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- clk_en  input  1  pipeline advance enable; gates enqueue only
- enq_valid  input  1  memory stage presents a store
- bubble_in  input  1  slot is a bubble
- exc_in  input  8  exception code of the slot; nonzero suppresses the store
- opcode  input  5  3–5 word, 6–8 halfword, 9–11 byte
- addr  input  32  effective byte address
- data  input  32  store source register value
- enq_ready  output  1  buffer can accept a store (not full)
- ld_addr  input  32  address of the load in the memory stage
- ld_hit  output  1  a queued store targets the same word as ld_addr
- mem_req  output  1  write request valid
- mem_ack  input  1  memory accepted the request this cycle
- mem_addr  output  32  word-aligned address {addr[31:2],2'b00}
- mem_wdata  output  32  lane-aligned write data
- mem_be  output  4  byte enables; bit i covers bits 8i+7:8i
- empty  output  1  no queued or in-flight stores
- count  output  PTR_W+1  number of occupied entries

Behaviour:
- Reset values (synchronous, rst has priority over every other input): count=0, empty=1, mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0, rd/wr pointers=0, FSM=IDLE.
- Enqueue fires at a clock edge when enq_valid && clk_en && !bubble_in && exc_in==0 && 3≤opcode≤11 && enq_ready.
- enq_ready = (count != DEPTH).
  - When full, enqueue is refused even if a pop happens in the same cycle; there is no pass-through.
  - Upstream stalls while enq_ready=0.
- Lane insertion is computed at enqueue, and the aligned data and byte enables are stored. Let o = addr[1:0].
  - Word: be=1111, wdata=data. Address low bits are ignored.
  - Half, o=00: be=0011, wdata={16'h0,data[15:0]}.
  - Half, o=01: be=0110, wdata={8'h0,data[15:0],8'h0}.
  - Half, o=1x: be=1100, wdata={data[15:0],16'h0}.
  - Byte: be=1<<o, wdata=data[7:0]<<(8*o). All other bytes are 0.
- FIFO pointers wrap modulo DEPTH.
  - Enqueue and pop in the same cycle leave count unchanged.
  - empty = (count==0).
- Drain FSM:
  - IDLE: mem_req=0. Go to REQ when count>0. An entry written at edge N raises mem_req in the cycle after edge N+1 at the earliest; IDLE inspects count registered at N.
  - REQ: mem_req=1. mem_addr, mem_wdata and mem_be come from the head entry and are registered, so they are stable while waiting.
    - On mem_ack: pop the head.
    - If count-1 > 0 (accounting for a same-cycle enqueue), stay in REQ and load the next head, which gives back-to-back drain.
    - Otherwise go to IDLE, with mem_req=0 and the data outputs holding their last values.
    - mem_ack while in IDLE is ignored.
- The head entry stays counted until its ack. ld_hit is therefore true for an in-flight store.
- ld_hit: OR over valid entries of (entry_addr[31:2]==ld_addr[31:2]). It is combinational and excludes a store enqueuing in the same cycle.
- clk_en=0 blocks enqueue only. Draining and ack handling continue.
- rst asserted while in REQ: mem_req drops at that edge and all entries are discarded. Memory must not complete a discarded request.

Test Plan:
- Reset, then a single word store (opcode 3, addr 0x1000, data 0xDEADBEEF) → mem_req rises 2 cycles later with mem_addr 0x1000, be 1111, wdata 0xDEADBEEF. Ack 1 cycle later → empty=1, mem_req=0 the next cycle.
- Byte stores (opcode 9, data 0x000000AB) at addr 0x2000–0x2003 → be 0001/0010/0100/1000, wdata 0xAB, 0xAB00, 0xAB0000, 0xAB000000, drained in order.
- Half stores (opcode 6, data 0x1234) at 0x3000/0x3001/0x3002/0x3003 → be 0011/0110/1100/1100, wdata 0x1234, 0x123400, 0x12340000, 0x12340000.
- Fill 4 entries with mem_ack held 0 → count=4, enq_ready=0, a fifth store is not accepted. Pulse ack plus enq_valid in the same cycle → count stays 3 after pop, the fifth store is accepted next cycle, and FIFO order is preserved through pointer wrap.
- Suppression cases each leave count unchanged: bubble_in=1, exc_in=0x82, clk_en=0, and opcode 12 (non-memory opcode).
- Queue a store to 0x4008 and set ld_addr=0x400B → ld_hit=1. ld_addr=0x400C → ld_hit=0. ld_hit stays 1 until the ack of that entry, then 0.
- rst asserted mid-REQ with 2 entries queued → next cycle mem_req=0, count=0, empty=1.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: lane-inserting store FIFO that drains committed stores to the
// data-memory write port over a req/ack handshake.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             enq_valid,
    input  logic             bubble_in,
    input  logic [7:0]       exc_in,
    input  logic [4:0]       opcode,
    input  logic [31:0]      addr,
    input  logic [31:0]      data,
    output logic             enq_ready,
    input  logic [31:0]      ld_addr,
    output logic             ld_hit,
    output logic             mem_req,
    input  logic             mem_ack,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_be,
    output logic             empty,
    output logic [PTR_W:0]   count
);
    typedef enum logic {IDLE, REQ} state_t;
    state_t state;
    logic [29:0] q_addr [DEPTH];
    logic [31:0] q_data [DEPTH];
    logic [3:0]  q_be   [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PTR_W-1:0] rd_ptr, wr_ptr, nxt_ptr;
    logic [1:0]  o;
    logic        is_word, is_half, is_byte, enq, pop;
    logic [31:0] ins_data;
    logic [3:0]  ins_be;
    logic        unused_ok;

    assign o         = addr[1:0];
    assign is_word   = opcode >= 5'd3 && opcode <= 5'd5;
    assign is_half   = opcode >= 5'd6 && opcode <= 5'd8;
    assign is_byte   = opcode >= 5'd9 && opcode <= 5'd11;
    assign enq_ready = count != (PTR_W+1)'(DEPTH);
    assign empty     = count == '0;
    assign enq       = enq_valid && clk_en && !bubble_in && exc_in == 8'h0 &&
                       (is_word || is_half || is_byte) && enq_ready;
    assign pop       = state == REQ && mem_ack;
    assign nxt_ptr   = rd_ptr + 1'b1;
    assign unused_ok = ^ld_addr[1:0];

    assign ins_be   = is_word ? 4'b1111 :
                      is_half ? (o == 2'd0 ? 4'b0011 : o == 2'd1 ? 4'b0110 : 4'b1100) :
                      4'b0001 << o;
    assign ins_data = is_word ? data :
                      is_half ? (o == 2'd0 ? {16'h0, data[15:0]} :
                                 o == 2'd1 ? {8'h0, data[15:0], 8'h0} : {data[15:0], 16'h0}) :
                      {24'h0, data[7:0]} << {o, 3'b000};

    // Live entries are tracked per slot so the word-match needs no pointer arithmetic.
    always_comb begin
        ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            ld_hit = ld_hit | (vld[i] && q_addr[i] == ld_addr[31:2]);
    end

    always_ff @(posedge clk)
        if (enq) begin
            q_addr[wr_ptr] <= addr[31:2];
            q_data[wr_ptr] <= ins_data;
            q_be[wr_ptr]   <= ins_be;
        end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            vld       <= '0;
        end else begin
            count <= count + (PTR_W+1)'(enq) - (PTR_W+1)'(pop);
            vld   <= (vld | (DEPTH'(enq) << wr_ptr)) & ~(DEPTH'(pop) << rd_ptr);
            if (enq)
                wr_ptr <= wr_ptr + 1'b1;
            if (state == IDLE) begin
                if (count != '0) begin
                    state     <= REQ;
                    mem_req   <= 1'b1;
                    mem_addr  <= {q_addr[rd_ptr], 2'b00};
                    mem_wdata <= q_data[rd_ptr];
                    mem_be    <= q_be[rd_ptr];
                end
            end else if (mem_ack) begin
                rd_ptr <= nxt_ptr;
                // With one entry left, a same-cycle enqueue becomes the next head directly.
                if (count > (PTR_W+1)'(1)) begin
                    mem_addr  <= {q_addr[nxt_ptr], 2'b00};
                    mem_wdata <= q_data[nxt_ptr];
                    mem_be    <= q_be[nxt_ptr];
                end else if (enq) begin
                    mem_addr  <= {addr[31:2], 2'b00};
                    mem_wdata <= ins_data;
                    mem_be    <= ins_be;
                end else begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            end
        end
    end
endmodule
